sap_controller_sequencer: RTL

SAP_CONTROLLER_SEQUENCER -- requirements
Module: sap_controller_sequencer

---
 rtl/sap_controller_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sap_controller_sequencer.sv
// SAP-1 style controller/sequencer: a one-hot six-state ring counter (T1..T6)
// that decodes the instruction opcode into a combinational control word.
// Optional feature macro: SAP_JUMP_EN adds JMP (opcode 0011, Ei+J in T4).
// With the macro undefined, 0011 behaves as a NOP and pc_jump is tied low.
module sap_controller_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       step_enable,
  output logic       pc_output_enable,
  output logic       pc_counter_enable,
  output logic       pc_jump,
  output logic       mar_load,
  output logic       ram_output_enable,
  output logic       ir_load,
  output logic       ir_output_enable,
  output logic       a_load,
  output logic       a_output_enable,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_output_enable,
  output logic       out_load,
  output logic [5:0] t_state,
  output logic       halted
);

  // The state encoding is the ring value itself; the halted state is all-zero.
  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } state_t;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_JMP = 4'b0011,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_t;

  state_t  state_q;
  state_t  state_d;
  opcode_t op;

  assign op      = opcode_t'(opcode);
  assign t_state = state_q;
  assign halted  = (state_q == ST_HALT);

  // Ring counter register; reset forces T1 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_T1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next ring state: advance when enabled, divert to the halted state when
  // HLT is in T4, and stay halted until reset.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_HALT && step_enable) begin
      case (state_q)
        ST_T1:   state_d = ST_T2;
        ST_T2:   state_d = ST_T3;
        ST_T3:   state_d = ST_T4;
        ST_T4:   state_d = (op == OP_HLT) ? ST_HALT : ST_T5;
        ST_T5:   state_d = ST_T6;
        ST_T6:   state_d = ST_T1;
        default: state_d = ST_T1;
      endcase
    end
  end

  // Control word decode from the current T-state and opcode.
  always_comb begin
    pc_output_enable  = 1'b0;
    pc_counter_enable = 1'b0;
    mar_load          = 1'b0;
    ram_output_enable = 1'b0;
    ir_load           = 1'b0;
    ir_output_enable  = 1'b0;
    a_load            = 1'b0;
    a_output_enable   = 1'b0;
    b_load            = 1'b0;
    alu_sub           = 1'b0;
    alu_output_enable = 1'b0;
    out_load          = 1'b0;
`ifdef SAP_JUMP_EN
    pc_jump           = 1'b0;
`endif
    case (state_q)
      ST_T1: begin
        pc_output_enable = 1'b1;
        mar_load         = 1'b1;
      end
      ST_T2: begin
        pc_counter_enable = 1'b1;
      end
      ST_T3: begin
        ram_output_enable = 1'b1;
        ir_load           = 1'b1;
      end
      ST_T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_output_enable = 1'b1;
            mar_load         = 1'b1;
          end
          OP_OUT: begin
            a_output_enable = 1'b1;
            out_load        = 1'b1;
          end
`ifdef SAP_JUMP_EN
          OP_JMP: begin
            ir_output_enable = 1'b1;
            pc_jump          = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_LDA: begin
            ram_output_enable = 1'b1;
            a_load            = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_output_enable = 1'b1;
            b_load            = 1'b1;
            // Subtract is selected a state early so the ALU output has
            // settled before it is driven onto the bus in T6.
            alu_sub           = (op == OP_SUB);
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op)
          OP_ADD, OP_SUB: begin
            alu_output_enable = 1'b1;
            a_load            = 1'b1;
            alu_sub           = (op == OP_SUB);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifndef SAP_JUMP_EN
  assign pc_jump = 1'b0;
`endif

endmodule
